// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES-bit segment per stage,
// segment carry registered between stages, valid/ready handshake with global stall and flush.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;

  logic             adv;
  logic             accept;
  logic             c0;
  logic [WIDTH-1:0] eb;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv && !flush;
  assign eb       = in_sub ? ~in_b : in_b;
  assign c0       = in_cin ^ in_sub;

  // Returns {carry into segment msb, segment carry-out, segment sum}.
  // Group carries are flat sum-of-products over group P/G, so no carry ripples between groups.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] fa,
                                             input logic [SEG-1:0] fb,
                                             input logic           cin);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] c;
    logic [NG-1:0]  gp;
    logic [NG-1:0]  gg;
    logic [NG:0]    gc;
    logic           term;
    p = fa ^ fb;
    g = fa & fb;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc    = '0;
    gc[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {c[SEG-1], gc[NG], p ^ c};
  endfunction

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_st
      localparam int OW = WIDTH - k*SEG;

      logic [OW-1:0]         ops_a;
      logic [OW-1:0]         ops_b;
      logic                  cin_s;
      logic                  sub_s;
      logic                  v_s;
      logic [TAG_W-1:0]      tag_s;
      logic [(k+1)*SEG-1:0]  sum_d;
      logic [SEG+1:0]        res;
      logic                  v_q;
      logic [(k+1)*SEG-1:0]  sum_q;
      logic [TAG_W-1:0]      tag_q;

      if (k == 0) begin : g_src
        assign ops_a = in_a;
        assign ops_b = eb;
        assign cin_s = c0;
        assign sub_s = in_sub;
        assign tag_s = in_tag;
        assign v_s   = accept;
        assign sum_d = res[SEG-1:0];
      end else begin : g_src
        assign ops_a = g_st[k-1].g_fwd.a_q;
        assign ops_b = g_st[k-1].g_fwd.b_q;
        assign cin_s = g_st[k-1].g_fwd.c_q;
        assign sub_s = g_st[k-1].g_fwd.sub_q;
        assign tag_s = g_st[k-1].tag_q;
        assign v_s   = g_st[k-1].v_q;
        assign sum_d = {res[SEG-1:0], g_st[k-1].sum_q};
      end

      assign res = cla_seg(ops_a[SEG-1:0], ops_b[SEG-1:0], cin_s);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     v_q <= 1'b0;
        else if (flush)  v_q <= 1'b0;
        else if (adv)    v_q <= v_s;
      end

      // Data only loads behind a valid op, so bubbles leave the last result in place.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          sum_q <= '0;
          tag_q <= '0;
        end else if (adv && v_s) begin
          sum_q <= sum_d;
          tag_q <= tag_s;
        end
      end

      if (k < STAGES - 1) begin : g_fwd
        logic [OW-SEG-1:0] a_q;
        logic [OW-SEG-1:0] b_q;
        logic              c_q;
        logic              sub_q;
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            sub_q <= 1'b0;
          end else if (adv && v_s) begin
            a_q   <= ops_a[OW-1:SEG];
            b_q   <= ops_b[OW-1:SEG];
            c_q   <= res[SEG];
            sub_q <= sub_s;
          end
        end
      end else begin : g_out
        logic cout_q;
        logic ovf_q;
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end else if (adv && v_s) begin
            cout_q <= res[SEG] ^ sub_s;
            ovf_q  <= res[SEG+1] ^ res[SEG];
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_st[STAGES-1].v_q;
  assign out_sum   = g_st[STAGES-1].sum_q;
  assign out_tag   = g_st[STAGES-1].tag_q;
  assign out_cout  = g_st[STAGES-1].g_out.cout_q;
  assign out_ovf   = g_st[STAGES-1].g_out.ovf_q;
  assign out_zero  = (out_sum == '0);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three instances (STAGES 1/2/4) on shared stimulus,
// each scored against an arithmetic reference model with per-instance result queues.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_sub;
  logic        in_cin;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;

  logic [2:0]       ir;
  logic [2:0]       ov;
  logic [2:0]       oc;
  logic [2:0]       oo;
  logic [2:0]       oz;
  logic [2:0][31:0] os;
  logic [2:0][3:0]  ot;

  int checks = 0;
  int errors = 0;
  logic [38:0] q [3][$];
  int acc_cnt [3];

  cla_pipe_adder #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_s1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(ov[0]), .out_ready(out_ready), .out_sum(os[0]), .out_cout(oc[0]),
    .out_ovf(oo[0]), .out_zero(oz[0]), .out_tag(ot[0]));

  cla_pipe_adder #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_s2 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(ov[1]), .out_ready(out_ready), .out_sum(os[1]), .out_cout(oc[1]),
    .out_ovf(oo[1]), .out_zero(oz[1]), .out_tag(ot[1]));

  cla_pipe_adder #(.WIDTH(32), .STAGES(4), .TAG_W(4)) u_s4 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(ov[2]), .out_ready(out_ready), .out_sum(os[2]), .out_cout(oc[2]),
    .out_ovf(oo[2]), .out_zero(oz[2]), .out_tag(ot[2]));

  // Record layout: {tag, zero, ovf, cout, sum}
  function automatic logic [38:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin,
                                        input logic [3:0] tag);
    longint ua, ub, ur, xa, xb, sr;
    logic [31:0] s;
    logic co, of;
    ua = longint'(a);
    ub = longint'(b);
    xa = longint'($signed(a));
    xb = longint'($signed(b));
    ur = sub ? (ua - ub - longint'(cin)) : (ua + ub + longint'(cin));
    sr = sub ? (xa - xb - longint'(cin)) : (xa + xb + longint'(cin));
    s  = ur[31:0];
    co = sub ? (ur < 0) : (ur > 64'sd4294967295);
    of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {tag, (s == 32'd0), of, co, s};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Sampled on the falling edge: these are exactly the values the next rising edge sees.
  task automatic scoreboard();
    logic [38:0] e;
    if (!resetn) return;
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && out_ready) begin
        if (q[i].size() == 0) begin
          chk($sformatf("extra_result_s%0d", i), 64'(ov[i]), 64'd0);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("result_s%0d", i), 64'({ot[i], oz[i], oo[i], oc[i], os[i]}), 64'(e));
        end
      end
      if (flush) q[i].delete();
      else if (in_valid && ir[i]) begin
        q[i].push_back(model(in_a, in_b, in_sub, in_cin, in_tag));
        acc_cnt[i]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    scoreboard();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, input logic [3:0] tag);
    in_a   = a;
    in_b   = b;
    in_sub = sub;
    in_cin = cin;
    in_tag = tag;
  endtask

  task automatic dir_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input logic [3:0] tag,
                        input logic [31:0] esum, input logic ecout, input logic eovf);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(a, b, sub, cin, tag);
    cycle();
    in_valid = 1'b0;
    chk({name, "_s1_valid"}, 64'(ov[0]), 64'd1);
    chk({name, "_s1_sum"}, 64'(os[0]), 64'(esum));
    chk({name, "_s2_early"}, 64'(ov[1]), 64'd0);
    cycle();
    chk({name, "_valid"}, 64'(ov[1]), 64'd1);
    chk({name, "_sum"}, 64'(os[1]), 64'(esum));
    chk({name, "_cout"}, 64'(oc[1]), 64'(ecout));
    chk({name, "_ovf"}, 64'(oo[1]), 64'(eovf));
    chk({name, "_zero"}, 64'(oz[1]), 64'(esum == 32'd0));
    chk({name, "_tag"}, 64'(ot[1]), 64'(tag));
    repeat (3) cycle();
  endtask

  initial begin
    logic [31:0] sta [4];
    logic [31:0] stb [4];
    logic        sts [4];
    logic [38:0] e1;
    int          idx;
    int          cyc;
    int          min_acc;
    logic        acc2;

    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    cycle();
    cycle();

    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_sum", 64'(os[1]), 64'd0);
    chk("rst_cout", 64'(oc[1]), 64'd0);
    chk("rst_ovf", 64'(oo[1]), 64'd0);
    chk("rst_tag", 64'(ot[1]), 64'd0);
    chk("rst_zero", 64'(oz), 64'h7);
    chk("rst_in_ready", 64'(ir), 64'h7);
    resetn = 1'b1;
    cycle();

    dir_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1, 32'h0000_0000, 1'b1, 1'b0);
    dir_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h2, 32'h8000_0000, 1'b0, 1'b1);
    dir_op("add_seg",   32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h3, 32'h0001_0000, 1'b0, 1'b0);
    dir_op("add_cin",   32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, 4'h4, 32'h0001_0000, 1'b0, 1'b0);
    dir_op("sub_neg",   32'd5,         32'd7,         1'b1, 1'b0, 4'h5, 32'hFFFF_FFFE, 1'b1, 1'b0);
    dir_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 4'h6, 32'h7FFF_FFFF, 1'b0, 1'b1);
    dir_op("sub_bin",   32'd10,        32'd3,         1'b1, 1'b1, 4'h7, 32'd6,         1'b0, 1'b0);

    // Four tagged ops back to back; consumer stalls for three cycles mid-stream.
    sta = '{32'h1111_1111, 32'hFFFF_0000, 32'h8000_0000, 32'd12};
    stb = '{32'h2222_2222, 32'h0001_0000, 32'h0000_0001, 32'd30};
    sts = '{1'b0, 1'b0, 1'b1, 1'b1};
    e1  = model(sta[1], stb[1], sts[1], 1'b0, 4'h6);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (idx < 4);
      if (idx < 4) drive(sta[idx], stb[idx], sts[idx], 1'b0, 4'(5 + idx));
      #1;
      if (c >= 3 && c <= 5) begin
        chk("stall_in_ready", 64'(ir[1]), 64'd0);
        chk("stall_valid", 64'(ov[1]), 64'd1);
        chk("stall_sum", 64'(os[1]), 64'(e1[31:0]));
        chk("stall_tag", 64'(ot[1]), 64'h6);
      end
      acc2 = in_valid && ir[1];
      cycle();
      if (acc2) idx++;
    end
    in_valid = 1'b0;
    chk("stream_all_sent", 64'(idx), 64'd4);
    chk("stream_drained", 64'(q[1].size()), 64'd0);

    // Flush with two ops in flight and a third offered.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(32'd1, 32'd2, 1'b0, 1'b0, 4'hA);
    cycle();
    drive(32'd3, 32'd4, 1'b0, 1'b0, 4'hB);
    cycle();
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(32'd5, 32'd6, 1'b0, 1'b0, 4'hC);
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", 64'(ov), 64'd0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("flush_no_result", 64'(ov), 64'd0);
    end
    chk("flush_queue_s2", 64'(q[1].size()), 64'd0);

    // Random traffic, then an asynchronous reset in the middle of the stream.
    for (int c = 0; c < 40; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      cycle();
    end
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 64'(ov), 64'd0);
    chk("midrst_zero", 64'(oz), 64'h7);
    chk("midrst_sum", 64'(os[2]), 64'd0);
    for (int i = 0; i < 3; i++) q[i].delete();
    cycle();
    resetn = 1'b1;

    for (int i = 0; i < 3; i++) acc_cnt[i] = 0;
    cyc     = 0;
    min_acc = 0;
    while (min_acc < 1000 && cyc < 8000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      cycle();
      cyc++;
      min_acc = acc_cnt[0];
      for (int i = 1; i < 3; i++) if (acc_cnt[i] < min_acc) min_acc = acc_cnt[i];
    end
    chk("random_budget", 64'(min_acc >= 1000), 64'd1);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 3; i++) chk($sformatf("random_drained_s%0d", i), 64'(q[i].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the integer datapath (ALU, address generation, divider iteration). The operand width is split into `STAGES` equal segments. Each segment is resolved in one pipeline stage with 4-bit lookahead groups and a segment-level lookahead tree. The segment carry is registered between stages. A valid/ready handshake, full-pipeline stall, flush and a pass-through tag let the adder sit directly in a stallable pipeline.

## Interface
- `WIDTH`, 32: operand width. `WIDTH/STAGES` must be a multiple of 4.
- `STAGES`, 2: pipeline stages (1..8), equal to the latency in cycles.
- `TAG_W`, 4: width of the sideband tag carried alongside each operation.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill every in-flight operation.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  adder accepts this cycle.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_sub`  in  1  1 = subtract.
- `in_cin`  in  1  carry-in (add) or borrow-in (sub).
- `in_tag`  in  TAG_W  sideband, returned unchanged.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  WIDTH  result.
- `out_cout`  out  1  carry-out (add) or borrow-out (sub).
- `out_ovf`  out  1  two's-complement signed overflow.
- `out_zero`  out  1  `out_sum == 0`.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- Effective operand: `eb = in_sub ? ~in_b : in_b`. Effective carry: `c0 = in_cin ^ in_sub`.
  - Add computes `a+b+cin`.
  - Subtract computes `a-b-cin`.
- Per bit: `p = a^eb`, `g = a&eb`.
- 4-bit groups produce internal carries plus group P/G. Group P/G feed a lookahead tree across the segment. No ripple across groups inside a segment.
- Stage k resolves bits `[k*SEG +: SEG]`, with `SEG = WIDTH/STAGES`, using the carry registered by stage k-1. Stage 0 uses `c0`.
  - Already-resolved low sum bits travel forward in pipeline registers.
  - Unresolved high operand bits (`a`, `eb`) travel forward in pipeline registers.
  - Tag and `in_sub` also travel forward.
- Final stage outputs:
  - `out_cout` = raw carry out of bit WIDTH-1 XOR `in_sub`.
  - `out_ovf` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - `out_zero` is derived from the registered sum.
- Advance rule: `adv = !out_valid || out_ready`.
  - The whole pipeline shifts one stage when `adv` = 1 and holds when `adv` = 0.
  - Bubbles are not compressed.
- `in_ready = adv`, combinational from `out_ready`.
- Accept: `in_valid && in_ready && !flush`.
- Flush:
  - On the flush edge, all stage valid bits clear. Data registers are don't-care.
  - `in_ready` is unaffected, but nothing is accepted in a flush cycle.
  - An output handshake (`out_valid && out_ready`) in the flush cycle still counts as delivered.
- Results emerge in acceptance order, with no loss or duplication under any `out_ready` pattern.

## Timing
- Reset (`resetn` = 0, asynchronous):
  - All stage valid bits = 0, so `out_valid` = 0.
  - `out_sum`, `out_cout`, `out_ovf`, `out_tag` = 0.
  - `out_zero` = 1, since it follows the reset sum of 0.
- Reset mid-operation discards everything in flight. The first result after reset release belongs to the first post-reset accept.
- Latency: an operation accepted at edge N is presented with `out_valid` = 1 after edge N+STAGES-1, provided no stall occurs.
- Throughput: one operation per cycle while `out_ready` = 1.
- Stall: with `out_valid` = 1 and `out_ready` = 0, all outputs are held stable and `in_ready` = 0.
- `STAGES` = 1: a single registered adder with latency 1.
- Critical path per stage is about log4(SEG) lookahead levels plus the registered carry-in. No combinational path from the `in_*` ports to the `out_*` ports.

## Test plan
- WIDTH=32, STAGES=2, add `0xFFFFFFFF + 0x00000001`, cin=0 → after 2 cycles: sum `0x00000000`, cout 1, zero 1, ovf 0.
- Add `0x7FFFFFFF + 1` → sum `0x80000000`, ovf 1, cout 0. Add `0x0000FFFF + 1` → `0x00010000`, which checks the carry across the segment boundary.
- Sub `5 - 7` → sum `0xFFFFFFFE`, cout (borrow) 1, ovf 0. Sub `0x80000000 - 1` → `0x7FFFFFFF`, ovf 1.
- Back-to-back stream of 4 tagged ops with `out_ready` low for 3 cycles mid-stream → `in_ready` low during the stall, outputs stable, all 4 results in order with correct tags.
- Flush with 2 ops in flight while `in_valid` is high → `out_valid` = 0 next cycle, no result for the flushed ops, nothing accepted in the flush cycle.
- `resetn` pulsed low mid-stream, then 1000 random ops for STAGES ∈ {1, 2, 4} against a reference model → exact match of sum, cout, ovf, zero and tag.
